md_unit: RTL and testbench

- Multiply/divide responder for the EX stage of the 5-stage MIPS pipeline; the far end of the EX_CTRL MD control fields (MDFunc, MDSign, MDHIWB, MDLOWB).
- Owns the HI/LO architectural registers.
- Executes MULT/MULTU over several cycles and DIV/DIVU with an iterative restoring divider.
- Raises a stall request to the hazard logic when EX needs HI/LO, or a new MD op, while the unit is busy.

---
 rtl/md_pkg.sv | 36 +++
 rtl/md_if.sv | 26 ++
 rtl/md_divider.sv | 74 +++++++
 rtl/md_unit.sv | 134 +++++++++++++
 tb/tb_md_unit.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared types and constants for the multiply/divide unit.
//   md_func_t  - MDFunc encoding driven by the EX control fields.
//                Encodings 101..111 are reserved and behave as NOP.
//   md_state_t - md_unit sequencer states.
//   mag32()    - absolute value of a 32-bit operand when signed.
//   is_md_op() - 1 for encodings that do work (NOP/reserved give 0).
package md_pkg;

  typedef enum logic [2:0] {
    MD_NOP  = 3'b000,
    MD_MUL  = 3'b001,
    MD_DIV  = 3'b010,
    MD_MTHI = 3'b011,
    MD_MTLO = 3'b100
  } md_func_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } md_state_t;

  localparam int MD_DIV_STEPS = 32;
  localparam int MD_MUL_CNT_W = 4;  // holds MUL_LAT up to 15
  localparam int MD_DIV_CNT_W = 6;  // holds MD_DIV_STEPS

  function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? -x : x;
  endfunction

  function automatic logic is_md_op(input logic [2:0] f);
    return (f == MD_MUL) || (f == MD_DIV) || (f == MD_MTHI) || (f == MD_MTLO);
  endfunction

endpackage

// File: rtl/md_if.sv
// md_if: EX-stage <-> multiply/divide unit signal bundle.
//   EX side (master) drives: md_start, md_func, md_sign, md_a, md_b, rd_hi, rd_lo.
//   MD side (slave) drives : hi, lo, busy, md_stall.
interface md_if;
  logic        md_start;
  logic [2:0]  md_func;
  logic        md_sign;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        rd_hi;
  logic        rd_lo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        md_stall;

  modport master (
    output md_start, md_func, md_sign, md_a, md_b, rd_hi, rd_lo,
    input  hi, lo, busy, md_stall
  );

  modport slave (
    input  md_start, md_func, md_sign, md_a, md_b, rd_hi, rd_lo,
    output hi, lo, busy, md_stall
  );
endinterface

// File: rtl/md_divider.sv
// md_divider: 32-step restoring unsigned divider core.
//   start_i      - load operands; the first step happens on the following edge.
//   dividend_i   - unsigned dividend, sampled with start_i.
//   divisor_i    - unsigned divisor, sampled with start_i.
//   done_o       - high during the cycle whose closing edge performs step 32.
//   quotient_o   - quotient, final in the cycle after done_o.
//   remainder_o  - remainder, final in the cycle after done_o.
// A zero divisor yields quotient 0xFFFFFFFF and remainder = dividend.
module md_divider
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  logic [31:0]             rem_q, rem_d;
  logic [31:0]             quo_q, quo_d;  // dividend bits shift out, quotient bits shift in
  logic [31:0]             dvs_q, dvs_d;
  logic [MD_DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [32:0]             shifted;

  // NOTE: every variable gets its default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    shifted = {rem_q, quo_q[31]};
    if (start_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
      cnt_d = MD_DIV_CNT_W'(MD_DIV_STEPS);
    end else if (cnt_q != '0) begin
      // Restoring step: keep the trial difference only when it does not go negative.
      if (shifted >= {1'b0, dvs_q}) begin
        rem_d = 32'(shifted - {1'b0, dvs_q});
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = shifted[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
      cnt_d = cnt_q - MD_DIV_CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign done_o      = (cnt_q == MD_DIV_CNT_W'(1));
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide responder owning HI/LO.
//   clk, rst_n - pipeline clock, asynchronous active-low reset.
//   bus        - md_if slave: request fields in; hi, lo, busy, md_stall out.
// MUL latches the 64-bit product at issue and exposes it after MUL_LAT busy
// cycles. DIV runs the unsigned core on operand magnitudes for 32 cycles, then
// a FIX cycle restores signs (or applies the divide-by-zero result).
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MUL_LAT = 5
) (
  input  logic clk,
  input  logic rst_n,
  md_if.slave  bus
);

  md_state_t               state_q, state_d;
  logic [31:0]             hi_q, hi_d, lo_q, lo_d;
  logic [MD_MUL_CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]             prod_q, prod_d;
  logic                    q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic                    div0_q, div0_d;
  logic [31:0]             a_raw_q, a_raw_d;

  logic        div_start, div_done, busy;
  logic [31:0] div_quo, div_rem;
  logic [63:0] a_ext, b_ext;

  // Sign-extending only in signed mode makes the low 64 bits of one
  // multiplier correct for both MULT and MULTU.
  assign a_ext = {{32{bus.md_sign & bus.md_a[31]}}, bus.md_a};
  assign b_ext = {{32{bus.md_sign & bus.md_b[31]}}, bus.md_b};

  md_divider u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (div_start),
    .dividend_i  (mag32(bus.md_a, bus.md_sign)),
    .divisor_i   (mag32(bus.md_b, bus.md_sign)),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    div0_d    = div0_q;
    a_raw_d   = a_raw_q;
    div_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.md_start) begin
          case (bus.md_func)
            MD_MTHI: hi_d = bus.md_a;
            MD_MTLO: lo_d = bus.md_a;
            MD_MUL: begin
              prod_d  = a_ext * b_ext;
              cnt_d   = MD_MUL_CNT_W'(MUL_LAT);
              state_d = MUL;
            end
            MD_DIV: begin
              div_start = 1'b1;
              q_neg_d   = bus.md_sign & (bus.md_a[31] ^ bus.md_b[31]);
              r_neg_d   = bus.md_sign & bus.md_a[31];
              div0_d    = (bus.md_b == '0);
              a_raw_d   = bus.md_a;
              state_d   = DIV;
            end
            default: ;  // NOP and reserved encodings
          endcase
        end
      end
      MUL: begin
        cnt_d = cnt_q - MD_MUL_CNT_W'(1);
        if (cnt_q == MD_MUL_CNT_W'(1)) begin
          {hi_d, lo_d} = prod_q;
          state_d      = IDLE;
        end
      end
      DIV: begin
        if (div_done) state_d = FIX;
      end
      FIX: begin
        // Divide by zero reports the raw dividend, so the sign fixup is skipped.
        if (div0_q) begin
          lo_d = 32'hFFFF_FFFF;
          hi_d = a_raw_q;
        end else begin
          lo_d = q_neg_q ? -div_quo : div_quo;
          hi_d = r_neg_q ? -div_rem : div_rem;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      div0_q  <= 1'b0;
      a_raw_q <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      div0_q  <= div0_d;
      a_raw_q <= a_raw_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign bus.busy     = busy;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.md_stall = busy && ((bus.md_start && is_md_op(bus.md_func)) || bus.rd_hi || bus.rd_lo);

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
  import md_pkg::*;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 33;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  md_if bus ();

  md_unit #(.MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: architectural HI/LO from plain 64-bit arithmetic.
  function automatic exp_t model(input logic [2:0] f, input logic s,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p, ua, ub;
    longint      sa_l, sb_l, q, r;
    e.lat = 0;
    if (f == MD_MUL) begin
      ua = {32'b0, a};
      ub = {32'b0, b};
      if (s) p = longint'($signed(a)) * longint'($signed(b));
      else   p = ua * ub;
      hi_m = p[63:32];
      lo_m = p[31:0];
      e.lat = MUL_LAT;
    end else if (f == MD_DIV) begin
      if (b == 0) begin
        lo_m = 32'hFFFF_FFFF;
        hi_m = a;
      end else if (s) begin
        sa_l = longint'($signed(a));
        sb_l = longint'($signed(b));
        q = sa_l / sb_l;
        r = sa_l % sb_l;
        lo_m = q[31:0];
        hi_m = r[31:0];
      end else begin
        lo_m = a / b;
        hi_m = a % b;
      end
      e.lat = DIV_LAT;
    end else if (f == MD_MTHI) begin
      hi_m = a;
    end else if (f == MD_MTLO) begin
      lo_m = a;
    end
    e.hi = hi_m;
    e.lo = lo_m;
    return e;
  endfunction

  // Monitor: every busy -> idle transition retires the oldest queued op.
  bit prev_busy = 1'b0;
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (bus.busy) begin
        busy_cnt++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          check("spurious_done", 64'(busy_cnt), 64'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_hi", bus.hi, e.hi);
          check("done_lo", bus.lo, e.lo);
          check("busy_cycles", 64'(busy_cnt), 64'(e.lat));
        end
        busy_cnt = 0;
      end
      prev_busy = bus.busy;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) check("idle_timeout", bus.busy, 1'b0);
  endtask

  task automatic issue(input logic [2:0] f, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input bit track);
    exp_t e;
    @(posedge clk); #1;
    bus.md_start = 1'b1;
    bus.md_func  = f;
    bus.md_sign  = s;
    bus.md_a     = a;
    bus.md_b     = b;
    if (track) begin
      e = model(f, s, a, b);
      if (f == MD_MUL || f == MD_DIV) sb.push_back(e);
    end
    @(negedge clk);
    if (f == MD_MTHI || f == MD_MTLO) check("mt_no_stall", bus.md_stall, 1'b0);
    @(posedge clk); #1;
    bus.md_start = 1'b0;
    bus.md_func  = MD_NOP;
    if (track && (f == MD_MTHI || f == MD_MTLO)) begin
      @(negedge clk);
      check("mt_hi", bus.hi, hi_m);
      check("mt_lo", bus.lo, lo_m);
      check("mt_busy", bus.busy, 1'b0);
    end
  endtask

  task automatic do_op(input string name, input logic [2:0] f, input logic s,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(f, s, a, b, 1'b1);
    wait_idle();
    check({name, "_hi"}, bus.hi, exp_hi);
    check({name, "_lo"}, bus.lo, exp_lo);
  endtask

  initial begin
    bus.md_start = 1'b0;
    bus.md_func  = MD_NOP;
    bus.md_sign  = 1'b0;
    bus.md_a     = '0;
    bus.md_b     = '0;
    bus.rd_hi    = 1'b1;
    bus.rd_lo    = 1'b1;
    #1;
    check("rst_hi", bus.hi, 32'h0);
    check("rst_lo", bus.lo, 32'h0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_stall", bus.md_stall, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_read_no_stall", bus.md_stall, 1'b0);
    bus.rd_hi = 1'b0;
    bus.rd_lo = 1'b0;

    // Directed arithmetic
    do_op("mult",     MD_MUL, 1'b1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    do_op("multu",    MD_MUL, 1'b0, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
    do_op("div",      MD_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("divu",     MD_DIV, 1'b0, 32'd100,       32'd7, 32'd2,         32'd14);
    do_op("div0_u",   MD_DIV, 1'b0, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
    do_op("div0_s",   MD_DIV, 1'b1, 32'h8765_4321, 32'd0, 32'h8765_4321, 32'hFFFF_FFFF);
    do_op("div_ovf",  MD_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // rd_hi two cycles after a DIV issue stalls until busy drops
    issue(MD_DIV, 1'b0, 32'd1000, 32'd7, 1'b1);
    @(posedge clk); #1;
    bus.rd_hi = 1'b1;
    begin
      int n = 0;
      @(negedge clk);
      while (bus.busy && n < 100) begin
        check("rd_hi_stall", bus.md_stall, 1'b1);
        @(negedge clk);
        n++;
      end
      check("rd_hi_released", bus.md_stall, 1'b0);
      check("rd_hi_value", bus.hi, 32'd6);
    end
    bus.rd_hi = 1'b0;

    // A new MUL presented while busy is ignored and stalls; NOP/reserved do not stall
    issue(MD_DIV, 1'b1, 32'hFFFF_0000, 32'd3, 1'b1);
    @(posedge clk); #1;
    bus.md_start = 1'b1;
    bus.md_func  = MD_MUL;
    bus.md_sign  = 1'b0;
    bus.md_a     = 32'd5;
    bus.md_b     = 32'd5;
    repeat (3) begin
      @(negedge clk);
      check("busy_mul_stall", bus.md_stall, 1'b1);
    end
    @(posedge clk); #1;
    bus.md_func = MD_NOP;
    @(negedge clk);
    check("busy_nop_no_stall", bus.md_stall, 1'b0);
    @(posedge clk); #1;
    bus.md_func = 3'b110;
    @(negedge clk);
    check("busy_rsv_no_stall", bus.md_stall, 1'b0);
    @(posedge clk); #1;
    bus.md_start = 1'b0;
    bus.md_func  = MD_NOP;
    wait_idle();
    check("ignored_mul_lo", bus.lo, lo_m);

    // MTLO / MTHI then read back the following cycle
    issue(MD_MTLO, 1'b0, 32'hCAFE_BABE, 32'd0, 1'b1);
    bus.rd_lo = 1'b1;
    @(negedge clk);
    check("mflo_no_stall", bus.md_stall, 1'b0);
    check("mflo_value", bus.lo, 32'hCAFE_BABE);
    bus.rd_lo = 1'b0;
    issue(MD_MTHI, 1'b0, 32'h0BAD_F00D, 32'd0, 1'b1);

    // Reset in the middle of a divide aborts it
    issue(MD_DIV, 1'b0, 32'hFFFF_FFFF, 32'd9, 1'b0);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    hi_m = '0;
    lo_m = '0;
    check("abort_hi", bus.hi, 32'h0);
    check("abort_lo", bus.lo, 32'h0);
    check("abort_busy", bus.busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_op("post_rst_mul", MD_MUL, 1'b0, 32'd7, 32'd6, 32'd0, 32'd42);

    // Randomized ops against the reference model
    for (int i = 0; i < 30; i++) begin
      logic [2:0]  f;
      logic        s;
      logic [31:0] a, b;
      int          sel;
      case ($urandom_range(0, 3))
        0: f = MD_MUL;
        1: f = MD_DIV;
        2: f = MD_MTHI;
        default: f = MD_MTLO;
      endcase
      s   = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 5);
      if (sel == 0) b = '0;
      else if (sel == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end else if (sel == 2) b = 32'($urandom_range(1, 20));
      issue(f, s, a, b, 1'b1);
      wait_idle();
    end

    begin
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (sb.size() != 0) check("scoreboard_drain", 64'(sb.size()), 64'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
